// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single data-memory port: IDLE -> ACCESS -> RESP.
// Define DMEM_ARB_MISALIGN_CHK_EN to reject misaligned half/word accesses with errx.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // requester 0
  input  logic                  req0,
  input  logic                  we0,
  input  logic [2:0]            func30,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic                  err0,
  // requester 1
  input  logic                  req1,
  input  logic                  we1,
  input  logic [2:0]            func31,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  err1,
  // memory side
  output logic                  mem_we,
  output logic [2:0]            mem_func3,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nx;

  logic                  last;      // port served by the most recent completed access
  logic                  win;       // port owning the in-flight transaction
  logic                  pick;
  logic                  any_req;
  logic                  misaligned;

  logic                  lat_we;
  logic [2:0]            lat_func3;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;

  assign any_req = req0 | req1;
  // Contention goes to the port that was not served last; a lone requester always wins.
  assign pick    = (req0 && req1) ? ~last : req1;

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // NOTE: state_nx gets its default before the case so no path leaves it unassigned
  // (that would infer a latch).
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last      <= 1'b1;
      win       <= 1'b0;
      lat_we    <= 1'b0;
      lat_func3 <= 3'h2;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        win       <= pick;
        lat_we    <= pick ? we1    : we0;
        lat_func3 <= pick ? func31 : func30;
        lat_addr  <= pick ? addr1  : addr0;
        lat_wdata <= pick ? wdata1 : wdata0;
      end
      if (state == ACCESS) begin
        last <= win;
        // Store responses carry no data, and rejected accesses must leave rdata intact.
        if (!lat_we && !misaligned) begin
          if (win) rdata1 <= mem_rdata;
          else     rdata0 <= mem_rdata;
        end
      end
    end
  end

`ifdef DMEM_ARB_MISALIGN_CHK_EN
  assign misaligned = ((lat_func3[1:0] == 2'b01) && lat_addr[0]) ||
                      ((lat_func3[1:0] == 2'b10) && (lat_addr[1:0] != 2'b00));
  assign err0       = rvalid0 && misaligned;
  assign err1       = rvalid1 && misaligned;
`else
  assign misaligned = 1'b0;
  assign err0       = 1'b0;
  assign err1       = 1'b0;
`endif

  assign gnt0    = (state == ACCESS) && !win;
  assign gnt1    = (state == ACCESS) &&  win;
  assign rvalid0 = (state == RESP)   && !win;
  assign rvalid1 = (state == RESP)   &&  win;

  // The latch registers only change when a new winner is taken, so the memory
  // address/data/func3 naturally hold their last values outside ACCESS.
  assign mem_we    = (state == ACCESS) && lat_we && !misaligned;
  assign mem_func3 = lat_func3;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-addressed memory model on the memory port.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_MISALIGN_CHK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_clr;
  logic        req0, we0, req1, we1;
  logic [2:0]  func30, func31;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, rvalid0, err0, gnt1, rvalid1, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_we;
  logic [2:0]  mem_func3;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [0:255];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .func30(func30), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .func31(func31), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
    .mem_we(mem_we), .mem_func3(mem_func3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Little-endian memory model: write on the clock edge, combinational load with extension.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata[7:0];
      if (mem_func3[1:0] != 2'b00) mem[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
      if (mem_func3[1:0] == 2'b10) begin
        mem[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
        mem[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
      end
    end
  end

  always_comb begin
    logic [7:0] a;
    a = mem_addr[7:0];
    case (mem_func3)
      3'd0:    mem_rdata = {{24{mem[a][7]}}, mem[a]};
      3'd1:    mem_rdata = {{16{mem[a+8'd1][7]}}, mem[a+8'd1], mem[a]};
      3'd4:    mem_rdata = {24'h0, mem[a]};
      3'd5:    mem_rdata = {16'h0, mem[a+8'd1], mem[a]};
      default: mem_rdata = {mem[a+8'd3], mem[a+8'd2], mem[a+8'd1], mem[a]};
    endcase
  end

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {mem[a+8'd3], mem[a+8'd2], mem[a+8'd1], mem[a]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int port, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
    if (port == 0) begin
      req0 = 1'b1; we0 = we; func30 = f3; addr0 = a; wdata0 = d;
    end else begin
      req1 = 1'b1; we1 = we; func31 = f3; addr1 = a; wdata1 = d;
    end
  endtask

  // Called at a falling edge while the arbiter is idle; returns at the falling edge of the next IDLE cycle.
  task automatic txn(input string tag, input int port, input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d, input logic exp_we,
                     input logic exp_err, input logic chk_rd, input logic [31:0] exp_rd);
    set_req(port, we, f3, a, d);
    @(posedge clk);
    @(negedge clk);
    check({tag, ".gnt"},    (port == 0) ? gnt0 : gnt1, 1'b1);
    check({tag, ".gnt_o"},  (port == 0) ? gnt1 : gnt0, 1'b0);
    check({tag, ".mem_we"}, mem_we, exp_we);
    check({tag, ".addr"},   mem_addr, a);
    check({tag, ".func3"},  mem_func3, f3);
    if (exp_we) check({tag, ".wdata"}, mem_wdata, d);
    if (port == 0) req0 = 1'b0; else req1 = 1'b0;
    // Fields change after the grant; the transaction must not notice.
    addr0 = 32'hFFFF_FFF0; addr1 = 32'hFFFF_FFF0;
    @(negedge clk);
    check({tag, ".rvalid"},   (port == 0) ? rvalid0 : rvalid1, 1'b1);
    check({tag, ".rvalid_o"}, (port == 0) ? rvalid1 : rvalid0, 1'b0);
    check({tag, ".err"},      (port == 0) ? err0 : err1, exp_err);
    check({tag, ".resp_we"},  mem_we, 1'b0);
    if (chk_rd) check({tag, ".rdata"}, (port == 0) ? rdata0 : rdata1, exp_rd);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; mem_clr = 1'b1;
    req0 = 1'b0; we0 = 1'b0; func30 = 3'd2; addr0 = 32'h10; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; func31 = 3'd2; addr1 = 32'h10; wdata1 = '0;
    repeat (2) @(negedge clk);

    check("rst.gnt0", gnt0, 1'b0);       check("rst.gnt1", gnt1, 1'b0);
    check("rst.rvalid0", rvalid0, 1'b0); check("rst.rvalid1", rvalid1, 1'b0);
    check("rst.err0", err0, 1'b0);       check("rst.err1", err1, 1'b0);
    check("rst.mem_we", mem_we, 1'b0);   check("rst.mem_func3", mem_func3, 3'h2);
    check("rst.mem_addr", mem_addr, 32'h0); check("rst.mem_wdata", mem_wdata, 32'h0);
    check("rst.rdata0", rdata0, 32'h0);  check("rst.rdata1", rdata1, 32'h0);

    // Both ports request continuously from reset: grants at cycles 1,4,7,10 alternate 0,1,0,1.
    req0 = 1'b1; req1 = 1'b1;
    rst = 1'b0; mem_clr = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("rr.gnt0[%0d]", k),    gnt0,    (k % 6) == 1);
      check($sformatf("rr.gnt1[%0d]", k),    gnt1,    (k % 6) == 4);
      check($sformatf("rr.rvalid0[%0d]", k), rvalid0, (k % 6) == 2);
      check($sformatf("rr.rvalid1[%0d]", k), rvalid1, (k % 6) == 5);
    end
    req0 = 1'b0; req1 = 1'b0;

    txn("sw0",  0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0);
    check("sw0.mem", mem_word(8'h10), 32'hDEADBEEF);
    txn("lw0",  0, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    txn("sb1",  1, 1'b1, 3'd0, 32'h11, 32'h0000_0080, 1'b1, 1'b0, 1'b0, 32'h0);
    check("sb1.mem", mem_word(8'h10), 32'hDEAD80EF);
    txn("lb1",  1, 1'b0, 3'd0, 32'h11, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFFFFFF80);
    txn("lbu1", 1, 1'b0, 3'd4, 32'h11, 32'h0, 1'b0, 1'b0, 1'b1, 32'h00000080);
    check("rdata0.hold", rdata0, 32'hDEADBEEF);

    // Misaligned word load and store.
    txn("lw0_mis", 0, 1'b0, 3'd2, 32'h12, 32'h0, 1'b0, CHK, 1'b1,
        CHK ? 32'hDEADBEEF : 32'h0000DEAD);
    txn("sw1_mis", 1, 1'b1, 3'd2, 32'h42, 32'h12345678, !CHK, CHK, 1'b0, 32'h0);
    txn("lw1_40",  1, 1'b0, 3'd2, 32'h40, 32'h0, 1'b0, 1'b0, 1'b1,
        CHK ? 32'h0 : 32'h56780000);

    // Port 0 served last, then reset hits the ACCESS cycle of a port-0 store.
    txn("lw0_b", 0, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD80EF);
    set_req(0, 1'b1, 3'd2, 32'h20, 32'hCAFEF00D);
    @(posedge clk);
    @(negedge clk);
    check("rstacc.gnt0", gnt0, 1'b1);
    check("rstacc.mem_we", mem_we, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rstacc.we_drop", mem_we, 1'b0);
    check("rstacc.gnt_drop", gnt0, 1'b0);
    @(negedge clk);
    rst = 1'b0; req0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rstacc.rvalid0[%0d]", k), rvalid0, 1'b0);
      check($sformatf("rstacc.rvalid1[%0d]", k), rvalid1, 1'b0);
    end
    check("rstacc.mem", mem_word(8'h20), 32'h0);
    set_req(0, 1'b0, 3'd2, 32'h10, 32'h0);
    set_req(1, 1'b0, 3'd2, 32'h10, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("rstacc.next_gnt0", gnt0, 1'b1);
    check("rstacc.next_gnt1", gnt1, 1'b0);
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
